// File: rtl/wb_write_buffer_if.sv
// Writeback buffer bus bundle.
// Groups the request side (in_*), the register-file write port (regwrite/WR/WD),
// the pending-write lookup (look_*) and the occupancy status (count/empty).
//   master : the writeback source / read-side logic that drives requests and lookups
//   slave  : the write buffer itself
interface wb_write_buffer_if #(
  parameter int DEPTH = 4,
  parameter int AW    = 5,
  parameter int DW    = 32
);
  localparam int CW = $clog2(DEPTH) + 1;

  logic          in_valid;
  logic          in_ready;
  logic [AW-1:0] in_reg;
  logic [DW-1:0] in_data;
  logic          wb_stall;
  logic          regwrite;
  logic [AW-1:0] WR;
  logic [DW-1:0] WD;
  logic [AW-1:0] look_reg;
  logic          look_hit;
  logic [DW-1:0] look_data;
  logic [CW-1:0] count;
  logic          empty;

  modport master (
    output in_valid, in_reg, in_data, wb_stall, look_reg,
    input  in_ready, regwrite, WR, WD, look_hit, look_data, count, empty
  );

  modport slave (
    input  in_valid, in_reg, in_data, wb_stall, look_reg,
    output in_ready, regwrite, WR, WD, look_hit, look_data, count, empty
  );
endinterface

// File: rtl/wb_write_buffer.sv
// Register-file write buffer.
// Queues writeback requests in a DEPTH-entry circular FIFO and drains one per
// cycle onto the register file write port. x0 requests are accepted but dropped.
// A combinational lookup reports the youngest queued value for look_reg so the
// read side can bypass writes that have not reached the register file yet.
// Ports:
//   clk, rst : clock, synchronous active-high reset
//   bus      : wb_write_buffer_if.slave (request, write port, lookup, status)

// Per-slot match: a slot is live when its distance from head is below count.
module wb_write_buffer_slot #(
  parameter int AW = 5,
  parameter int PW = 2,
  parameter int CW = 3
) (
  input  logic [PW-1:0] slot,
  input  logic [PW-1:0] head,
  input  logic [CW-1:0] count,
  input  logic [AW-1:0] ent_reg,
  input  logic [AW-1:0] look_reg,
  output logic          match
);
  logic [PW-1:0] age;

  assign age   = slot - head;
  assign match = ({1'b0, age} < count) && (ent_reg == look_reg) && (look_reg != '0);
endmodule

module wb_write_buffer #(
  parameter int DEPTH = 4,
  parameter int AW    = 5,
  parameter int DW    = 32
) (
  input  logic               clk,
  input  logic               rst,
  wb_write_buffer_if.slave   bus
);
  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  typedef struct packed {
    logic [AW-1:0] rd;
    logic [DW-1:0] data;
  } wb_req_t;

  wb_req_t [DEPTH-1:0] ent;
  logic    [PW-1:0]    head, tail;
  logic    [CW-1:0]    count;
  logic                empty, full, push, pop;
  logic    [DEPTH-1:0] match;
  logic                hit;
  logic    [DW-1:0]    hit_data;
  logic    [PW-1:0]    idx;

  assign empty = (count == '0);
  assign full  = (count == CW'(DEPTH));
  // Ready is state-only: a same-cycle drain does not free a slot for push.
  assign push  = bus.in_valid && !full && (bus.in_reg != '0);
  assign pop   = !empty && !bus.wb_stall;

  always_ff @(posedge clk) begin
    if (rst) begin
      head  <= '0;
      tail  <= '0;
      count <= '0;
    end else begin
      if (push) tail <= tail + PW'(1);
      if (pop)  head <= head + PW'(1);
      count <= count + CW'(push) - CW'(pop);
    end
  end

  // Payload storage needs no reset; liveness comes from head/count.
  always_ff @(posedge clk) begin
    if (push) ent[tail] <= '{rd: bus.in_reg, data: bus.in_data};
  end

  for (genvar s = 0; s < DEPTH; s++) begin : g_slot
    wb_write_buffer_slot #(.AW(AW), .PW(PW), .CW(CW)) u_slot (
      .slot     (PW'(s)),
      .head     (head),
      .count    (count),
      .ent_reg  (ent[s].rd),
      .look_reg (bus.look_reg),
      .match    (match[s])
    );
  end

  // Walk from oldest to youngest; the last match seen wins.
  always_comb begin
    hit      = 1'b0;
    hit_data = '0;
    idx      = '0;
    for (int j = 0; j < DEPTH; j++) begin
      idx = head + PW'(j);
      if (match[idx]) begin
        hit      = 1'b1;
        hit_data = ent[idx].data;
      end
    end
  end

  assign bus.in_ready  = !full;
  assign bus.regwrite  = pop;
  assign bus.WR        = empty ? '0 : ent[head].rd;
  assign bus.WD        = empty ? '0 : ent[head].data;
  assign bus.look_hit  = hit;
  assign bus.look_data = hit_data;
  assign bus.count     = count;
  assign bus.empty     = empty;
endmodule
